aes_spi_slave: RTL and testbench

- Next-generation SPI slave for the AES accelerator; the whole block runs in the system clock domain.
- Oversamples sclk, mosi and cs_n; frames a transaction with cs_n.
- Shifts in text, key (parametrised width) and direction byte, then hands them to the cipher core with a start pulse.
- Captures the core result on done and shifts it out on miso. Adds framing, abort and error reporting.

---
 rtl/aes_spi_slave.sv | 217 +++++++++++++++++++++
 tb/tb_aes_spi_slave.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_slave.sv
// aes_spi_slave
//    SPI slave front end for the AES accelerator, clocked entirely by clk.
//    sclk, mosi and cs_n are oversampled through a synchroniser chain.
//    A frame delivers {text, key, dir}, MSB first. The block then issues
//    start_o to the cipher core, waits for done_i, and shifts the result out
//    on miso. A frame that cs_n ends early raises frame_err_o.
//
//    Ports
//       clk, reset_n            system clock, async active-low reset
//       sclk, mosi, cs_n        SPI from the master (asynchronous to clk)
//       miso                    SPI data to the master
//       key_o, text_o, dir_o    captured key / block / direction byte
//       start_o                 one-clk pulse when the captured fields are valid
//       busy_o                  high from start_o until the last result bit
//       result_i, done_i        cipher core result and its valid strobe
//       frame_err_o             one-clk pulse on an aborted frame
//
//    Build option
//       AES_SPI_STATUS_EN : the readout is preceded by a status byte
//                           {dir[0], 000, key256, key192, err_sticky, 1}.
//
//    state     | meaning
//    ----------+--------------------------------------------------------
//    IDLE      | waiting for cs_n to fall, miso = 0
//    SHIFT_IN  | collecting text/key/dir bits on sclk rising edges
//    WAIT      | start issued, waiting for done_i from the core
//    SHIFT_OUT | shifting the result out on sclk falling edges
module aes_spi_slave #(
   parameter int KEY_W       = 128,
   parameter int BLK_W       = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             sclk,
   input  logic             mosi,
   input  logic             cs_n,
   output logic             miso,
   output logic [KEY_W-1:0] key_o,
   output logic [BLK_W-1:0] text_o,
   output logic [7:0]       dir_o,
   output logic             start_o,
   output logic             busy_o,
   input  logic [BLK_W-1:0] result_i,
   input  logic             done_i,
   output logic             frame_err_o
);

   localparam int IN_BITS = BLK_W + KEY_W + 8;
`ifdef AES_SPI_STATUS_EN
   localparam int OUT_BITS = BLK_W + 8;
`else
   localparam int OUT_BITS = BLK_W;
`endif
   localparam int CNT_W = $clog2(IN_BITS + 1);
   localparam logic [CNT_W-1:0] IN_END   = CNT_W'(IN_BITS);
   localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_BITS - 1);
   localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT_IN, WAIT, SHIFT_OUT} state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
   logic                   sclk_d, cs_d;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, sclk_fall, cs_rise, cs_fall, cs_low;

   logic [CNT_W-1:0]       cnt;
   logic [IN_BITS-1:0]     in_sr;
   logic [OUT_BITS-1:0]    out_sr;
   logic [OUT_BITS-1:0]    load_word;

   logic shift_in_en, load_en, abort, out_load, out_shift, out_done;
   logic cnt_inc, cnt_clr;

   // cs_n idles high, so its chain resets to 1 to avoid a false edge after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sclk_sync <= '0;
         mosi_sync <= '0;
         cs_sync   <= '1;
         sclk_d    <= 1'b0;
         cs_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
         sclk_d    <= sclk_s;
         cs_d      <= cs_s;
      end
   end

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign cs_s      = cs_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign cs_rise   = cs_s & ~cs_d;
   assign cs_fall   = ~cs_s & cs_d;
   // Delayed cs level: still low in the clk where the cs_n rise is seen, so
   // a final sclk edge coinciding with the rise is still taken.
   assign cs_low    = ~cs_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      shift_in_en = 1'b0;
      load_en     = 1'b0;
      abort       = 1'b0;
      out_load    = 1'b0;
      out_shift   = 1'b0;
      out_done    = 1'b0;
      cnt_inc     = 1'b0;
      cnt_clr     = 1'b0;
      case (state)
         IDLE: begin
            if (cs_fall) begin
               cnt_clr   = 1'b1;
               state_nxt = SHIFT_IN;
            end
         end
         SHIFT_IN: begin
            if (cnt == IN_END) begin
               load_en   = 1'b1;
               state_nxt = WAIT;
            end else begin
               shift_in_en = sclk_rise & cs_low;
               cnt_inc     = shift_in_en;
               if (cs_rise && !(shift_in_en && cnt == IN_LAST)) begin
                  abort     = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         WAIT: begin
            if (done_i) begin
               out_load  = 1'b1;
               cnt_clr   = 1'b1;
               state_nxt = SHIFT_OUT;
            end
         end
         SHIFT_OUT: begin
            out_shift = sclk_fall & cs_low;
            cnt_inc   = sclk_rise & cs_low;
            if (cnt_inc && cnt == OUT_LAST) begin
               out_done  = 1'b1;
               state_nxt = IDLE;
            end else if (cs_rise) begin
               abort     = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef AES_SPI_STATUS_EN
   logic err_sticky;
   logic status_sent;

   assign status_sent = (state == SHIFT_OUT) && cnt_inc && (cnt == CNT_W'(7));
   assign load_word   = {dir_o[0], 3'b000, (KEY_W == 256), (KEY_W == 192),
                         err_sticky, 1'b1, result_i};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)         err_sticky <= 1'b0;
      else if (abort)       err_sticky <= 1'b1;
      else if (status_sent) err_sticky <= 1'b0;
   end
`else
   assign load_word = result_i;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt         <= '0;
         in_sr       <= '0;
         out_sr      <= '0;
         key_o       <= '0;
         text_o      <= '0;
         dir_o       <= '0;
         start_o     <= 1'b0;
         busy_o      <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         start_o     <= load_en;
         frame_err_o <= abort;

         if (cnt_clr)      cnt <= '0;
         else if (cnt_inc) cnt <= cnt + CNT_W'(1);

         if (shift_in_en) in_sr <= {in_sr[IN_BITS-2:0], mosi_s};

         if (load_en) begin
            text_o <= in_sr[IN_BITS-1 -: BLK_W];
            key_o  <= in_sr[8 +: KEY_W];
            dir_o  <= in_sr[7:0];
         end

         if (load_en)                busy_o <= 1'b1;
         else if (out_done || abort) busy_o <= 1'b0;

         // Clearing the register on exit is what returns miso to 0 in IDLE.
         if (out_load)               out_sr <= load_word;
         else if (out_done || abort) out_sr <= '0;
         else if (out_shift)         out_sr <= {out_sr[OUT_BITS-2:0], 1'b0};
      end
   end

   assign miso = out_sr[OUT_BITS-1];

endmodule

// File: tb/tb_aes_spi_slave.sv
// Bench for aes_spi_slave. A master model drives SPI frames; expected
// load/abort events and expected readout words are queued as stimulus is
// issued, and a monitor pops and compares whenever the DUT presents them.
module tb_aes_spi_slave;

   localparam int KEY_W   = 128;
   localparam int BLK_W   = 128;
   localparam int IN_BITS = BLK_W + KEY_W + 8;
`ifdef AES_SPI_STATUS_EN
   localparam int OUT_BITS = BLK_W + 8;
`else
   localparam int OUT_BITS = BLK_W;
`endif
   localparam time HALF = 50;

   logic             clk, reset_n, sclk, mosi, cs_n, miso;
   logic [KEY_W-1:0] key_o;
   logic [BLK_W-1:0] text_o, result_i;
   logic [7:0]       dir_o;
   logic             start_o, busy_o, done_i, frame_err_o;

   aes_spi_slave #(.KEY_W(KEY_W), .BLK_W(BLK_W), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
      .miso(miso), .key_o(key_o), .text_o(text_o), .dir_o(dir_o),
      .start_o(start_o), .busy_o(busy_o), .result_i(result_i),
      .done_i(done_i), .frame_err_o(frame_err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit               is_err;
      logic [BLK_W-1:0] text;
      logic [KEY_W-1:0] key;
      logic [7:0]       dir;
   } ev_t;

   ev_t                 exp_q[$];
   logic [OUT_BITS-1:0] out_exp_q[$];
   logic [OUT_BITS-1:0] out_act_q[$];
   ev_t                 mon_e;
   logic [OUT_BITS-1:0] mon_exp, mon_act;

   int n_checks = 0;
   int n_errors = 0;

   // Reference state: last loaded fields and the pending-error flag.
   bit               sticky = 1'b0;
   logic [BLK_W-1:0] cur_text = '0;
   logic [KEY_W-1:0] cur_key  = '0;
   logic [7:0]       cur_dir  = '0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [BLK_W-1:0] rand_blk();
      logic [BLK_W-1:0] v;
      for (int i = 0; i < BLK_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [KEY_W-1:0] rand_key();
      logic [KEY_W-1:0] v;
      for (int i = 0; i < KEY_W / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [KEY_W-1:0] seq_key();
      logic [KEY_W-1:0] v;
      for (int b = 0; b < KEY_W / 8; b++) v[KEY_W-1-8*b -: 8] = 8'(b);
      return v;
   endfunction

   function automatic logic [OUT_BITS-1:0] expected_out(input logic [7:0] d, input logic [BLK_W-1:0] r);
`ifdef AES_SPI_STATUS_EN
      return {d[0], 3'b000, 1'(KEY_W == 256), 1'(KEY_W == 192), sticky, 1'b1, r};
`else
      return r;
`endif
   endfunction

   // Monitor: compares whatever the DUT presents against the queued expectations.
   always @(negedge clk) begin
      if (start_o === 1'b1) begin
         if (exp_q.size() == 0 || exp_q[0].is_err) begin
            n_checks++; n_errors++;
            $display("FAIL start_unexpected: got start_o=1 expected no start");
         end else begin
            mon_e = exp_q.pop_front();
            check("text_o", 512'(text_o), 512'(mon_e.text));
            check("key_o",  512'(key_o),  512'(mon_e.key));
            check("dir_o",  512'(dir_o),  512'(mon_e.dir));
         end
      end
      if (frame_err_o === 1'b1) begin
         n_checks++;
         if (exp_q.size() == 0 || !exp_q[0].is_err) begin
            n_errors++;
            $display("FAIL frame_err_unexpected: got frame_err_o=1 expected no error");
         end else begin
            void'(exp_q.pop_front());
         end
      end
      if (out_act_q.size() != 0) begin
         mon_act = out_act_q.pop_front();
         if (out_exp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL readout_unexpected: got %0h expected nothing", mon_act);
         end else begin
            mon_exp = out_exp_q.pop_front();
            check("readout", 512'(mon_act), 512'(mon_exp));
         end
      end
   end

   task automatic send_bits(input logic [IN_BITS-1:0] f, input int nbits, input bit simul);
      for (int i = 0; i < nbits; i++) begin
         if (i < IN_BITS) mosi = f[IN_BITS-1-i];
         else             mosi = 1'($urandom_range(0, 1));
         #(HALF);
         sclk = 1'b1;
         if (simul && i == nbits - 1) cs_n = 1'b1;
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic read_bits(input int n, output logic [OUT_BITS-1:0] v);
      v = '0;
      for (int i = 0; i < n; i++) begin
         #(HALF);
         sclk = 1'b1;
         v = {v[OUT_BITS-2:0], miso};
         #(HALF);
         sclk = 1'b0;
      end
   endtask

   task automatic abort_in(input int nbits);
      ev_t e;
      e.is_err = 1'b1; e.text = '0; e.key = '0; e.dir = '0;
      exp_q.push_back(e);
      cs_n = 1'b0;
      #(2*HALF);
      send_bits({rand_blk(), rand_key(), 8'($urandom)}, nbits, 1'b0);
      cs_n = 1'b1;
      #(4*HALF);
      check("abort_text_kept", 512'(text_o), 512'(cur_text));
      check("abort_key_kept",  512'(key_o),  512'(cur_key));
      check("abort_dir_kept",  512'(dir_o),  512'(cur_dir));
      check("abort_busy",      512'(busy_o), 512'(0));
      sticky = 1'b1;
      #(2*HALF);
   endtask

   // stop_at = 0: full readout; otherwise stop after stop_at bits by
   // raising cs_n (by_reset = 0) or by asserting reset_n (by_reset = 1).
   task automatic do_txn(input logic [BLK_W-1:0] t, input logic [KEY_W-1:0] k,
                         input logic [7:0] d, input logic [BLK_W-1:0] r,
                         input int extra, input bit simul, input int stop_at, input bit by_reset);
      ev_t e;
      logic [OUT_BITS-1:0] v, ex;
      e.is_err = 1'b0; e.text = t; e.key = k; e.dir = d;
      exp_q.push_back(e);
      cs_n = 1'b0;
      #(2*HALF);
      send_bits({t, k, d}, IN_BITS + extra, simul);
      cur_text = t; cur_key = k; cur_dir = d;
      #(4*HALF);
      check("busy_after_start", 512'(busy_o), 512'(1));
      if (simul) begin
         cs_n = 1'b0;
         #(2*HALF);
      end
      result_i = r;
      @(negedge clk) done_i = 1'b1;
      @(negedge clk) done_i = 1'b0;
      result_i = rand_blk();
      #(2*HALF);
      ex = expected_out(d, r);
      if (stop_at == 0) begin
         out_exp_q.push_back(ex);
         sticky = 1'b0;
         read_bits(OUT_BITS, v);
         out_act_q.push_back(v);
         #(4*HALF);
         check("busy_after_readout", 512'(busy_o), 512'(0));
         check("miso_idle",          512'(miso),   512'(0));
      end else begin
         read_bits(stop_at, v);
         check("partial_readout", 512'(v), 512'(ex >> (OUT_BITS - stop_at)));
         if (by_reset) begin
            reset_n = 1'b0;
            cs_n    = 1'b1;
            #2;
            check("rst_miso",  512'(miso),   512'(0));
            check("rst_busy",  512'(busy_o), 512'(0));
            check("rst_key",   512'(key_o),  512'(0));
            check("rst_text",  512'(text_o), 512'(0));
            sticky = 1'b0;
            cur_text = '0; cur_key = '0; cur_dir = '0;
            #20;
            @(negedge clk) reset_n = 1'b1;
         end else begin
            if (stop_at >= 8) sticky = 1'b0;
            e.is_err = 1'b1;
            exp_q.push_back(e);
            cs_n = 1'b1;
            sticky = 1'b1;
            #(4*HALF);
            check("out_abort_busy", 512'(busy_o), 512'(0));
            check("out_abort_miso", 512'(miso),   512'(0));
         end
      end
      cs_n = 1'b1;
      #(4*HALF);
   endtask

   localparam logic [BLK_W-1:0] FIX_TEXT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [BLK_W-1:0] FIX_RES  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      reset_n = 1'b0; sclk = 1'b0; mosi = 1'b0; cs_n = 1'b1;
      result_i = '0; done_i = 1'b0;
      #23;
      check("reset_miso",      512'(miso),        512'(0));
      check("reset_key",       512'(key_o),       512'(0));
      check("reset_text",      512'(text_o),      512'(0));
      check("reset_dir",       512'(dir_o),       512'(0));
      check("reset_start",     512'(start_o),     512'(0));
      check("reset_busy",      512'(busy_o),      512'(0));
      check("reset_frame_err", 512'(frame_err_o), 512'(0));
      @(negedge clk) reset_n = 1'b1;
      #100;

      do_txn(FIX_TEXT, seq_key(), 8'h00, FIX_RES, 0, 1'b0, 0, 1'b0);
      abort_in(100);
      do_txn(FIX_TEXT, seq_key(), 8'h01, FIX_RES, 0, 1'b0, 0, 1'b0);

      for (int i = 0; i < 4; i++)
         do_txn(rand_blk(), rand_key(), 8'($urandom), rand_blk(),
                (i == 1) ? 3 : 0, (i == 2), 0, 1'b0);

      do_txn(rand_blk(), rand_key(), 8'($urandom), rand_blk(), 0, 1'b0, 20, 1'b0);
      do_txn(rand_blk(), rand_key(), 8'($urandom), rand_blk(), 0, 1'b0, 60, 1'b1);

      result_i = rand_blk();
      @(negedge clk) done_i = 1'b1;
      @(negedge clk) done_i = 1'b0;
      #200;
      check("idle_done_busy", 512'(busy_o), 512'(0));
      check("idle_done_miso", 512'(miso),   512'(0));

      do_txn(rand_blk(), rand_key(), 8'($urandom), rand_blk(), 0, 1'b0, 0, 1'b0);

      #500;
      check("events_pending",  512'(exp_q.size()),     512'(0));
      check("readout_pending", 512'(out_exp_q.size()), 512'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
